// File: rtl/binary_morph_open3x3_if.sv
// Binary video stream bundle: sync, pixel valid, 1-bit pixel and pass-through side data.
interface binary_morph_open3x3_if #(
    parameter int unsigned DATA_W = 8
);
    logic              vs;
    logic              hs;
    logic              clken;
    logic              imgbit;
    logic [DATA_W-1:0] imgdata;

    modport master (output vs, hs, clken, imgbit, imgdata);
    modport slave  (input  vs, hs, clken, imgbit, imgdata);
endinterface

// File: rtl/binary_morph_open3x3.sv
// 3x3 binary opening: erosion stage then dilation stage, each 2 clk, with sync and side data
// carried alongside so every output lags its input by exactly 4 clk.
module binary_morph_open3x3 #(
    parameter int unsigned IMG_W  = 800,
    parameter int unsigned DATA_W = 8,
    parameter bit          VS_POL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    binary_morph_open3x3_if.slave  pre_i,
    binary_morph_open3x3_if.master post_o
);
    localparam int unsigned AW = $clog2(IMG_W);
    localparam int unsigned CW = $clog2(IMG_W + 1);

    logic [2:0]             st_vs, st_hs, st_clken, st_bit;
    logic [2:0][DATA_W-1:0] st_data;

    assign st_vs[0]    = pre_i.vs;
    assign st_hs[0]    = pre_i.hs;
    assign st_clken[0] = pre_i.clken;
    assign st_bit[0]   = pre_i.imgbit;
    assign st_data[0]  = pre_i.imgdata;

    for (genvar s = 0; s < 2; s++) begin : g_stage
        // The dilation stage only trusts windows built entirely from the erosion stage's
        // unmasked output, which starts two rows/cols later than its own stream.
        localparam int unsigned Border = (s == 0) ? 2 : 4;

        logic [IMG_W-1:0]       lb0_q, lb1_q;
        logic [8:0]             win_q, win_d;
        logic [CW-1:0]          col_q, col_d;
        logic [2:0]             row_q, row_d;
        logic                   clken_prev_q;
        logic                   ok_q, ok_d;
        logic                   res_q, res_d;
        logic                   wr_en;
        logic [AW-1:0]          addr;
        logic [1:0]             vs_q, hs_q, clken_q;
        logic [1:0][DATA_W-1:0] data_q;

        // Past the end of the line buffer, writes are dropped and reads stick at the last cell.
        assign wr_en = (col_q < CW'(IMG_W));
        assign addr  = wr_en ? col_q[AW-1:0] : AW'(IMG_W - 1);

        always_comb begin
            col_d = col_q;
            if (!st_clken[s]) begin
                col_d = '0;
            end else if (col_q != CW'(IMG_W)) begin
                col_d = col_q + 1'b1;
            end

            // Row only needs to count up to the border threshold.
            row_d = row_q;
            if (st_vs[s] == VS_POL) begin
                row_d = '0;
            end else if (clken_prev_q && !st_clken[s] && (row_q != 3'(Border))) begin
                row_d = row_q + 1'b1;
            end

            win_d = win_q;
            if (st_clken[s]) begin
                win_d = {win_q[5:0], lb1_q[addr], lb0_q[addr], st_bit[s]};
            end

            ok_d  = st_clken[s] && (row_q >= 3'(Border)) && (col_q >= CW'(Border));
            res_d = ok_q && ((s == 0) ? (&win_q) : (|win_q));
        end

        always_ff @(posedge clk) begin
            if (st_clken[s] && wr_en) begin
                lb0_q[addr] <= st_bit[s];
                lb1_q[addr] <= lb0_q[addr];
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n) begin
                col_q        <= '0;
                row_q        <= '0;
                win_q        <= '0;
                clken_prev_q <= 1'b0;
                ok_q         <= 1'b0;
                res_q        <= 1'b0;
                vs_q         <= '0;
                hs_q         <= '0;
                clken_q      <= '0;
                data_q       <= '0;
            end else begin
                col_q        <= col_d;
                row_q        <= row_d;
                win_q        <= win_d;
                clken_prev_q <= st_clken[s];
                ok_q         <= ok_d;
                res_q        <= res_d;
                vs_q         <= {vs_q[0], st_vs[s]};
                hs_q         <= {hs_q[0], st_hs[s]};
                clken_q      <= {clken_q[0], st_clken[s]};
                data_q       <= {data_q[0], st_data[s]};
            end
        end

        assign st_vs[s+1]    = vs_q[1];
        assign st_hs[s+1]    = hs_q[1];
        assign st_clken[s+1] = clken_q[1];
        assign st_bit[s+1]   = res_q;
        assign st_data[s+1]  = data_q[1];
    end

    assign post_o.vs      = st_vs[2];
    assign post_o.hs      = st_hs[2];
    assign post_o.clken   = st_clken[2];
    assign post_o.imgbit  = st_bit[2];
    assign post_o.imgdata = st_data[2];
endmodule

// File: tb/tb_binary_morph_open3x3.sv
// Directed bench for binary_morph_open3x3 on a 40x30 frame (800x600 scaled by 1/20).
module tb_binary_morph_open3x3;
    localparam int unsigned W  = 40;
    localparam int unsigned H  = 30;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    binary_morph_open3x3_if #(.DATA_W(DW)) pre_if ();
    binary_morph_open3x3_if #(.DATA_W(DW)) post_if ();

    binary_morph_open3x3 #(
        .IMG_W (W),
        .DATA_W(DW),
        .VS_POL(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pre_i (pre_if),
        .post_o(post_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Output frame capture, indexed by output line/pixel position.
    logic [W-1:0] cap [H];
    int           orow = 0;
    int           ocol = 0;
    logic         pclk_prev = 1'b0;

    always @(negedge clk) begin
        if (post_if.vs) begin
            orow = 0;
            ocol = 0;
            for (int r = 0; r < H; r++) cap[r] = '0;
        end else if (post_if.clken) begin
            if (orow < H && ocol < W) cap[orow][ocol] = post_if.imgbit;
            ocol++;
        end else begin
            if (pclk_prev) orow++;
            ocol = 0;
        end
        pclk_prev = post_if.clken;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 0 zeros, 1 ones, 2 single dot, 3 5x5 block, 4 block plus 2x2 speck
    function automatic bit in_pix(int pat, int r, int c);
        case (pat)
            1:       return 1'b1;
            2:       return (r == 5 && c == 5);
            3:       return (r >= 10 && r <= 14 && c >= 10 && c <= 14);
            4:       return (r >= 10 && r <= 14 && c >= 10 && c <= 14) ||
                            (r >= 4 && r <= 5 && c >= 4 && c <= 5);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_pix(int pat, int r, int c);
        case (pat)
            1:       return (r >= 4 && c >= 4);
            3, 4:    return (r >= 12 && r <= 16 && c >= 12 && c <= 16);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_frame(input int pat);
        pre_if.clken = 1'b0;
        pre_if.hs    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            pre_if.vs = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            pre_if.vs = 1'b0;
        end
        for (int r = 0; r < H; r++) begin
            for (int i = 0; i < 3; i++) begin
                step();
                pre_if.hs    = (i < 2);
                pre_if.clken = 1'b0;
            end
            for (int c = 0; c < W; c++) begin
                step();
                pre_if.clken   = 1'b1;
                pre_if.imgbit  = in_pix(pat, r, c);
                pre_if.imgdata = DW'(r * W + c);
            end
            step();
            pre_if.clken  = 1'b0;
            pre_if.imgbit = 1'b0;
        end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic check_frame(input int pat, input string name);
        logic [W-1:0] e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) e[c] = exp_pix(pat, r, c);
            n_checks++;
            if (cap[r] !== e) begin
                n_fail++;
                $display("FAIL %s row %0d: got %h expected %h", name, r, cap[r], e);
            end
        end
    endtask

    task automatic test_reset();
        logic [19:0] cpat;
        logic        hist [20];
        logic        exp_clken;
        cpat = 20'b1101_0111_0011_1011_0110;
        rst_n = 1'b1;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if ({post_if.vs, post_if.hs, post_if.clken, post_if.imgbit, post_if.imgdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b/%b/%b/%b/%h expected all 0", post_if.vs, post_if.hs,
                     post_if.clken, post_if.imgbit, post_if.imgdata);
        end
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            pre_if.clken   = 1'b1;
            pre_if.imgbit  = 1'b1;
            pre_if.imgdata = 8'hA5;
            pre_if.hs      = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 2) rst_n = 1'b0;
            pre_if.clken = cpat[k];
            hist[k]      = cpat[k];
            @(negedge clk);
            if (k <= 2) begin
                n_checks++;
                if ({post_if.vs, post_if.hs, post_if.clken, post_if.imgbit, post_if.imgdata} !== '0)
                begin
                    n_fail++;
                    $display("FAIL reset_hold cycle %0d: got %b/%b/%b/%b/%h expected all 0", k,
                             post_if.vs, post_if.hs, post_if.clken, post_if.imgbit,
                             post_if.imgdata);
                end
            end else begin
                exp_clken = (k >= 6) ? hist[k-4] : 1'b0;
                n_checks++;
                if (post_if.clken !== exp_clken) begin
                    n_fail++;
                    $display("FAIL reset_release_clken cycle %0d: got %b expected %b", k,
                             post_if.clken, exp_clken);
                end
            end
        end
        step();
        pre_if.clken = 1'b0;
        pre_if.hs    = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [DW+2:0] v [16];
        logic [DW+2:0] got;
        for (int k = 0; k < 16; k++) begin
            step();
            v[k] = {(k % 7 == 0), (k % 3 == 0), (((k >> 1) ^ k) & 1) == 1, DW'(k * 37 + 5)};
            {pre_if.vs, pre_if.hs, pre_if.clken, pre_if.imgdata} = v[k];
            pre_if.imgbit = 1'b1;
            @(negedge clk);
            if (k >= 4) begin
                got = {post_if.vs, post_if.hs, post_if.clken, post_if.imgdata};
                n_checks++;
                if (got !== v[k-4]) begin
                    n_fail++;
                    $display("FAIL passthrough cycle %0d: got %h expected %h", k, got, v[k-4]);
                end
                if (!post_if.clken) begin
                    n_checks++;
                    if (post_if.imgbit !== 1'b0) begin
                        n_fail++;
                        $display("FAIL imgbit_gated cycle %0d: got %b expected 0", k,
                                 post_if.imgbit);
                    end
                end
            end
        end
        step();
        {pre_if.vs, pre_if.hs, pre_if.clken, pre_if.imgbit, pre_if.imgdata} = '0;
    endtask

    task automatic test_all_ones();
        drive_frame(1);
        check_frame(1, "all_ones");
    endtask

    task automatic test_speck();
        drive_frame(2);
        check_frame(2, "single_speck");
    endtask

    task automatic test_block();
        drive_frame(3);
        check_frame(3, "block5x5");
    endtask

    task automatic test_block_speck();
        drive_frame(4);
        check_frame(4, "block_plus_speck");
    endtask

    task automatic test_back_to_back();
        drive_frame(1);
        check_frame(1, "b2b_frame1");
        drive_frame(0);
        check_frame(0, "b2b_frame2_zero");
    endtask

    initial begin
        rst_n          = 1'b1;
        pre_if.vs      = 1'b0;
        pre_if.hs      = 1'b0;
        pre_if.clken   = 1'b0;
        pre_if.imgbit  = 1'b0;
        pre_if.imgdata = '0;
        test_reset();
        test_passthrough();
        test_all_ones();
        test_speck();
        test_block();
        test_block_speck();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
